// File: rtl/mc14500_pkg.sv
// Shared opcode definitions for the MC14500B-compatible industrial control unit.
package mc14500_pkg;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

endpackage

// File: rtl/mc14500_lu.sv
// Combinational logic unit: computes the next result-register value from
// the opcode, the current RR and the enable-gated data bit.
module mc14500_lu
    import mc14500_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic       i_rr,
    input  logic       i_d,
    output logic       o_rr
);

    // Opcodes outside the logic group leave RR unchanged.
    always_comb begin
        o_rr = i_rr;
        case (i_op)
            OP_LD:   o_rr = i_d;
            OP_LDC:  o_rr = ~i_d;
            OP_AND:  o_rr = i_rr & i_d;
            OP_ANDC: o_rr = i_rr & ~i_d;
            OP_OR:   o_rr = i_rr | i_d;
            OP_ORC:  o_rr = i_rr | ~i_d;
            OP_XNOR: o_rr = ~(i_rr ^ i_d);
            default: o_rr = i_rr;
        endcase
    end

endmodule

// File: rtl/mc14500_icu.sv
// MC14500B-compatible single-bit control unit: one instruction per X2 edge,
// with I/O enable gating, one-instruction skip and one-cycle flag pulses.
module mc14500_icu
    import mc14500_pkg::*;
(
    input  logic       X2,
    input  logic       RST,
    input  logic [3:0] I,
    inout  wire        DATA,
    output logic       X1,
    output logic       WRITE,
    output logic       RR,
    output logic       JMP,
    output logic       RTN,
    output logic       FLAG_O,
    output logic       FLAG_F
);

    logic r_rr;
    logic r_ien;
    logic r_oen;
    logic r_skip;
    logic r_write;
    logic r_jmp;
    logic r_rtn;
    logic r_flagO;
    logic r_flagF;
    logic r_dout;

    logic w_d;
    logic w_rrNext;

    // IEN and OEN themselves load from the raw bus; only the logic group sees gated data.
    assign w_d = DATA & r_ien;

    mc14500_lu u_lu (
        .i_op (I),
        .i_rr (r_rr),
        .i_d  (w_d),
        .o_rr (w_rrNext)
    );

    // Pulses default low every cycle so they last exactly one clock; a pending
    // skip swallows the whole instruction, including any skip it would request.
    always_ff @(posedge X2) begin
        if (RST) begin
            r_rr    <= 1'b0;
            r_ien   <= 1'b0;
            r_oen   <= 1'b0;
            r_skip  <= 1'b0;
            r_write <= 1'b0;
            r_jmp   <= 1'b0;
            r_rtn   <= 1'b0;
            r_flagO <= 1'b0;
            r_flagF <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_skip  <= 1'b0;
            r_write <= 1'b0;
            r_jmp   <= 1'b0;
            r_rtn   <= 1'b0;
            r_flagO <= 1'b0;
            r_flagF <= 1'b0;
            if (!r_skip) begin
                r_rr <= w_rrNext;
                case (I)
                    OP_NOPO: r_flagO <= 1'b1;
                    OP_STO: begin
                        if (r_oen) begin
                            r_dout  <= r_rr;
                            r_write <= 1'b1;
                        end
                    end
                    OP_STOC: begin
                        if (r_oen) begin
                            r_dout  <= ~r_rr;
                            r_write <= 1'b1;
                        end
                    end
                    OP_IEN:  r_ien   <= DATA;
                    OP_OEN:  r_oen   <= DATA;
                    OP_JMP:  r_jmp   <= 1'b1;
                    OP_RTN: begin
                        r_rtn  <= 1'b1;
                        r_skip <= 1'b1;
                    end
                    OP_SKZ:  r_skip  <= ~r_rr;
                    OP_NOPF: r_flagF <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign DATA   = r_write ? r_dout : 1'bz;
    assign X1     = ~X2;
    assign WRITE  = r_write;
    assign RR     = r_rr;
    assign JMP    = r_jmp;
    assign RTN    = r_rtn;
    assign FLAG_O = r_flagO;
    assign FLAG_F = r_flagF;

endmodule

// File: tb/tb_mc14500_icu.sv
// Directed-vector bench for mc14500_icu with hand-computed expected values.
`timescale 1ns/1ps
module tb_mc14500_icu;
    import mc14500_pkg::*;

    logic       X2 = 1'b0;
    logic       RST;
    logic [3:0] I;
    logic       tbDrive;
    logic       tbVal;
    wire        DATA;
    logic       X1, WRITE, RR, JMP, RTN, FLAG_O, FLAG_F;

    int checks = 0;
    int errors = 0;

    assign DATA = tbDrive ? tbVal : 1'bz;

    mc14500_icu dut (
        .X2     (X2),
        .RST    (RST),
        .I      (I),
        .DATA   (DATA),
        .X1     (X1),
        .WRITE  (WRITE),
        .RR     (RR),
        .JMP    (JMP),
        .RTN    (RTN),
        .FLAG_O (FLAG_O),
        .FLAG_F (FLAG_F)
    );

    always #5 X2 = ~X2;

    task automatic checkOutput(input string tag, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // Present one instruction on the falling edge, then sample 1ns after the rising edge.
    task automatic applyStimulus(input logic [3:0] op, input logic drv, input logic val);
        @(negedge X2);
        I       = op;
        tbDrive = drv;
        tbVal   = val;
        @(posedge X2);
        #1;
    endtask

    task automatic checkPulses(input string tag, input logic w, input logic j,
                               input logic r, input logic fo, input logic ff);
        checkOutput({tag, ".WRITE"},  WRITE,  w);
        checkOutput({tag, ".JMP"},    JMP,    j);
        checkOutput({tag, ".RTN"},    RTN,    r);
        checkOutput({tag, ".FLAG_O"}, FLAG_O, fo);
        checkOutput({tag, ".FLAG_F"}, FLAG_F, ff);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1;
        I = OP_NOPO;
        tbDrive = 1'b1;
        tbVal = 1'b0;

        applyStimulus(OP_NOPO, 1'b1, 1'b0);
        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("reset.RR", RR, 1'b0);
        checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("X1 high phase", X1, 1'b0);
        RST = 1'b0;

        applyStimulus(OP_IEN, 1'b1, 1'b1);
        applyStimulus(OP_OEN, 1'b1, 1'b1);
        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("LD d1", RR, 1'b1);
        applyStimulus(OP_LDC, 1'b1, 1'b1);
        checkOutput("LDC d1", RR, 1'b0);
        applyStimulus(OP_IEN, 1'b1, 1'b0);
        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("LD gated", RR, 1'b0);
        applyStimulus(OP_IEN, 1'b1, 1'b1);

        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("LD setup", RR, 1'b1);
        applyStimulus(OP_AND, 1'b1, 1'b0);
        checkOutput("AND d0", RR, 1'b0);
        applyStimulus(OP_OR, 1'b1, 1'b1);
        checkOutput("OR d1", RR, 1'b1);
        applyStimulus(OP_ANDC, 1'b1, 1'b0);
        checkOutput("ANDC d0", RR, 1'b1);
        applyStimulus(OP_ORC, 1'b1, 1'b1);
        checkOutput("ORC d1", RR, 1'b1);
        applyStimulus(OP_XNOR, 1'b1, 1'b0);
        checkOutput("XNOR first", RR, 1'b0);
        applyStimulus(OP_XNOR, 1'b1, 1'b0);
        checkOutput("XNOR second", RR, 1'b1);

        applyStimulus(OP_STO, 1'b0, 1'b0);
        checkOutput("STO.WRITE", WRITE, 1'b1);
        checkOutput("STO.DATA", DATA, 1'b1);
        applyStimulus(OP_NOPO, 1'b0, 1'b0);
        checkOutput("STO end.WRITE", WRITE, 1'b0);
        checkOutput("NOPO.FLAG_O", FLAG_O, 1'b1);
        applyStimulus(OP_STOC, 1'b0, 1'b0);
        checkOutput("STOC.WRITE", WRITE, 1'b1);
        checkOutput("STOC.DATA", DATA, 1'b0);
        checkOutput("STOC keeps RR", RR, 1'b1);
        applyStimulus(OP_NOPO, 1'b0, 1'b0);
        applyStimulus(OP_OEN, 1'b1, 1'b0);
        applyStimulus(OP_STO, 1'b0, 1'b0);
        checkOutput("STO blocked.WRITE", WRITE, 1'b0);
        applyStimulus(OP_OEN, 1'b1, 1'b1);

        applyStimulus(OP_LD, 1'b1, 1'b0);
        checkOutput("LD d0", RR, 1'b0);
        applyStimulus(OP_SKZ, 1'b1, 1'b0);
        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("SKZ taken.RR", RR, 1'b0);
        checkPulses("SKZ taken", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("skip one only", RR, 1'b1);
        applyStimulus(OP_SKZ, 1'b1, 1'b0);
        applyStimulus(OP_LD, 1'b1, 1'b0);
        checkOutput("SKZ not taken.RR", RR, 1'b0);

        applyStimulus(OP_RTN, 1'b1, 1'b0);
        checkPulses("RTN", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(OP_NOPF, 1'b1, 1'b0);
        checkPulses("RTN skip", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_NOPF, 1'b1, 1'b0);
        checkOutput("NOPF.FLAG_F", FLAG_F, 1'b1);
        applyStimulus(OP_RTN, 1'b1, 1'b0);
        applyStimulus(OP_SKZ, 1'b1, 1'b0);
        applyStimulus(OP_NOPF, 1'b1, 1'b0);
        checkOutput("skipped SKZ no skip", FLAG_F, 1'b1);
        applyStimulus(OP_JMP, 1'b1, 1'b0);
        checkPulses("JMP", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_NOPO, 1'b1, 1'b0);
        checkPulses("NOPO", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(OP_NOPO, 1'b1, 1'b0);
        checkOutput("NOPO back-to-back", FLAG_O, 1'b1);

        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("pre-reset RR", RR, 1'b1);
        applyStimulus(OP_RTN, 1'b1, 1'b0);
        RST = 1'b1;
        applyStimulus(OP_NOPF, 1'b1, 1'b0);
        RST = 1'b0;
        checkOutput("mid reset.RR", RR, 1'b0);
        checkPulses("mid reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("post reset IEN=0", RR, 1'b0);
        applyStimulus(OP_STO, 1'b0, 1'b0);
        checkOutput("post reset OEN=0", WRITE, 1'b0);
        applyStimulus(OP_IEN, 1'b1, 1'b1);
        applyStimulus(OP_LD, 1'b1, 1'b1);
        checkOutput("post reset LD", RR, 1'b1);
        @(negedge X2);
        #1;
        checkOutput("X1 low phase", X1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
